// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the SPRAM slave FSM state type.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ERR1    = 2'd2,
    ST_ERR2    = 2'd3
  } spram_state_e;

endpackage

// File: rtl/peripheral_spram_1r1w.sv
// Single-port-style memory wrapper: one registered read port, one
// byte-enabled write port. Read-first when both hit the same word.
module peripheral_spram_1r1w #(
  parameter int ABITS      = 8,
  parameter int DBITS      = 32,
  parameter     TECHNOLOGY = "GENERIC"
) (
  input  logic                 clk,
  input  logic [ABITS-1:0]     waddr,
  input  logic                 we,
  input  logic [DBITS/8-1:0]   be,
  input  logic [DBITS-1:0]     din,
  input  logic [ABITS-1:0]     raddr,
  input  logic                 re,
  output logic [DBITS-1:0]     dout
);

  // Only the behavioural array exists today; the selector is kept for
  // future technology-specific macros.
  localparam bit unused_tech = (TECHNOLOGY != "");

  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];

  // Byte-lane write and registered read; no reset on storage.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBITS/8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
    if (re) dout <= mem[raddr];
  end

endmodule

// File: rtl/peripheral_spram_ahb3_fwd.sv
// AHB3-Lite SPRAM slave with posted writes and read-after-write forwarding.
// Optional error responses are enabled with PERIPHERAL_SPRAM_AHB3_ERROR_EN.
module peripheral_spram_ahb3_fwd
  import peripheral_ahb3_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int PLEN        = 32,
  parameter int XLEN        = 32,
  parameter int WAIT_STATES = 0,
  parameter     TECHNOLOGY  = "GENERIC"
) (
  input  logic             HRESETn,
  input  logic             HCLK,
  input  logic             HSEL,
  input  logic [PLEN-1:0]  HADDR,
  input  logic [XLEN-1:0]  HWDATA,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  logic [1:0]       HTRANS,
  input  logic             HMASTLOCK,
  input  logic             HREADY,
  output logic [XLEN-1:0]  HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP
);

  localparam int         NB    = XLEN / 8;
  localparam int         OFFS  = $clog2(NB);
  localparam int         ABITS = $clog2(MEM_DEPTH);
  localparam logic [1:0] WS    = 2'(WAIT_STATES);

  // Lanes covered by a transfer of 2**size bytes at addr; anything wider
  // than the bus simply enables every lane.
  function automatic logic [NB-1:0] byte_en(input logic [2:0] size,
                                            input logic [PLEN-1:0] addr);
    int off;
    int sz;
    byte_en = '0;
    sz  = int'(size);
    off = int'(addr & PLEN'(NB - 1));
    for (int i = 0; i < NB; i++) begin
      if (sz >= OFFS || (i >> sz) == (off >> sz)) byte_en[i] = 1'b1;
    end
  endfunction

`ifdef PERIPHERAL_SPRAM_AHB3_ERROR_EN
  // Out-of-range word, oversize transfer, or address misaligned to size.
  function automatic logic xfer_err(input logic [2:0] size,
                                    input logic [PLEN-1:0] addr);
    logic [PLEN-1:0] hi;
    logic [PLEN-1:0] msk;
    hi  = addr >> (OFFS + ABITS);
    msk = (PLEN'(1) << size) - PLEN'(1);
    xfer_err = (hi != '0) || (int'(size) > OFFS) || ((addr & msk) != '0);
  endfunction
`endif

  logic                 accept;
  logic                 acc_err;
  logic                 acc_rd;
  logic                 acc_wr;
  logic [ABITS-1:0]     haddr_idx;

  spram_state_e         state, state_nxt;
  logic [1:0]           cnt, cnt_nxt;
  logic                 ready_c;
  logic                 resp_c;

  logic                 wr_vld_p0;
  logic [ABITS-1:0]     wr_idx_p0;
  logic [NB-1:0]        wr_be_p0;
  logic                 wr_vld_p1;
  logic [ABITS-1:0]     wr_idx_p1;
  logic [NB-1:0]        wr_be_p1;
  logic [XLEN-1:0]      wr_data_p1;

  logic                 rd_vld_p1;
  logic                 hit_p0;
  logic                 hit_p1;
  logic [NB-1:0]        fwd_be_nxt;
  logic [XLEN-1:0]      fwd_data_nxt;
  logic [NB-1:0]        fwd_be_p1;
  logic [XLEN-1:0]      fwd_data_p1;
  logic [XLEN-1:0]      mem_q;

  logic                 unused_ok;
  assign unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK, HADDR};

  assign accept    = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign haddr_idx = HADDR[OFFS +: ABITS];

`ifdef PERIPHERAL_SPRAM_AHB3_ERROR_EN
  assign acc_err = accept & xfer_err(HSIZE, HADDR);
  assign HRESP   = resp_c;
`else
  logic unused_resp;
  assign acc_err     = 1'b0;
  assign HRESP       = HRESP_OKAY;
  assign unused_resp = resp_c;
`endif

  assign acc_rd    = accept & ~acc_err & ~HWRITE;
  assign acc_wr    = accept & ~acc_err &  HWRITE;
  assign HREADYOUT = ready_c;

  // FSM state and wait counter register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and response: read wait states and the two-cycle error.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_c   = 1'b1;
    resp_c    = HRESP_OKAY;
    case (state)
      ST_RD_WAIT: begin
        ready_c = 1'b0;
        if (cnt <= 2'd1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      ST_ERR1: begin
        ready_c   = 1'b0;
        resp_c    = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        resp_c    = HRESP_ERROR;
        state_nxt = ST_IDLE;
      end
      default: ;
    endcase
    // A transfer presented in the last error cycle is accepted as from IDLE.
    if (state == ST_IDLE || state == ST_ERR2) begin
      if (acc_err) begin
        state_nxt = ST_ERR1;
      end else if (acc_rd && WS != 2'd0) begin
        state_nxt = ST_RD_WAIT;
        cnt_nxt   = WS;
      end
    end
  end

  // Control for the write and read data phases (p0: write in data phase,
  // p1: posted write committing / read data phase).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_vld_p0 <= 1'b0;
      wr_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      wr_vld_p1 <= wr_vld_p0 & HREADY;
      if (HREADY) begin
        wr_vld_p0 <= acc_wr;
        rd_vld_p1 <= acc_rd;
      end
    end
  end

  // Write address/lanes at the address phase, HWDATA at the data phase.
  always_ff @(posedge HCLK) begin
    if (acc_wr) begin
      wr_idx_p0 <= haddr_idx;
      wr_be_p0  <= byte_en(HSIZE, HADDR);
    end
    if (wr_vld_p0 && HREADY) begin
      wr_idx_p1  <= wr_idx_p0;
      wr_be_p1   <= wr_be_p0;
      wr_data_p1 <= HWDATA;
    end
  end

  assign hit_p0 = wr_vld_p0 & (wr_idx_p0 == haddr_idx);
  assign hit_p1 = wr_vld_p1 & (wr_idx_p1 == haddr_idx);

  // Bytes the memory read will miss: the committing write, overlaid by the
  // newer write whose data is on HWDATA right now.
  always_comb begin
    fwd_be_nxt   = '0;
    fwd_data_nxt = wr_data_p1;
    for (int i = 0; i < NB; i++) begin
      if (hit_p1 && wr_be_p1[i]) fwd_be_nxt[i] = 1'b1;
      if (hit_p0 && wr_be_p0[i]) begin
        fwd_be_nxt[i]           = 1'b1;
        fwd_data_nxt[8*i +: 8]  = HWDATA[8*i +: 8];
      end
    end
  end

  // Snapshot the forwarded bytes together with the memory read.
  always_ff @(posedge HCLK) begin
    if (acc_rd) begin
      fwd_be_p1   <= fwd_be_nxt;
      fwd_data_p1 <= fwd_data_nxt;
    end
  end

  // Read data: forwarded lanes over memory lanes, zero outside a read.
  always_comb begin
    HRDATA = '0;
    if (rd_vld_p1) begin
      for (int i = 0; i < NB; i++) begin
        HRDATA[8*i +: 8] = fwd_be_p1[i] ? fwd_data_p1[8*i +: 8] : mem_q[8*i +: 8];
      end
    end
  end

  peripheral_spram_1r1w #(
    .ABITS      (ABITS),
    .DBITS      (XLEN),
    .TECHNOLOGY (TECHNOLOGY)
  ) u_mem (
    .clk   (HCLK),
    .waddr (wr_idx_p1),
    .we    (wr_vld_p1),
    .be    (wr_be_p1),
    .din   (wr_data_p1),
    .raddr (haddr_idx),
    .re    (acc_rd),
    .dout  (mem_q)
  );

endmodule

// File: tb/tb_peripheral_spram_ahb3_fwd.sv
// Scoreboard bench for peripheral_spram_ahb3_fwd: a zero-wait instance and a
// two-wait-state instance share the bus; one is selected at a time.
module tb_peripheral_spram_ahb3_fwd;
  import peripheral_ahb3_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        hsel0, hsel2;
  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2;
  logic        hresp0, hresp2;

  logic        use2;
  logic        rdy, resp;
  logic [31:0] rdata;

  assign rdy   = use2 ? hreadyout2 : hreadyout0;
  assign resp  = use2 ? hresp2     : hresp0;
  assign rdata = use2 ? hrdata2    : hrdata0;

  always #5 HCLK = ~HCLK;

  peripheral_spram_ahb3_fwd #(
    .MEM_DEPTH(256), .PLEN(32), .XLEN(32), .WAIT_STATES(0), .TECHNOLOGY("GENERIC")
  ) u_dut0 (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(hsel0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(hreadyout0), .HRDATA(hrdata0),
    .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  peripheral_spram_ahb3_fwd #(
    .MEM_DEPTH(256), .PLEN(32), .XLEN(32), .WAIT_STATES(2), .TECHNOLOGY("GENERIC")
  ) u_dut2 (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(hsel2), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(hreadyout2), .HRDATA(hrdata2),
    .HREADYOUT(hreadyout2), .HRESP(hresp2)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q [$];
  logic [31:0] mem0 [256];
  logic [31:0] mem2 [256];

  // state of the transfer currently in its data phase
  logic        dp_act = 1'b0;
  logic        dp_rd  = 1'b0;
  logic        dp_err = 1'b0;
  int          dp_ws  = 0;
  logic [31:0] dp_wdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tb_be(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      HSIZE_BYTE:  tb_be = 4'b0001 << a;
      HSIZE_HWORD: tb_be = a[1] ? 4'b1100 : 4'b0011;
      default:     tb_be = 4'b1111;
    endcase
  endfunction

  function automatic logic tb_err(input logic [2:0] sz, input logic [31:0] a);
`ifdef PERIPHERAL_SPRAM_AHB3_ERROR_EN
    tb_err = (a >= 32'h400) || (sz > HSIZE_WORD) ||
             (sz == HSIZE_HWORD && a[0]) || (sz == HSIZE_WORD && a[1:0] != 2'b00);
`else
    tb_err = 1'b0 & (|sz) & (|a);
`endif
  endfunction

  // One address phase; completes the previous data phase and checks it.
  // Called at posedge+1, returns at posedge+1 of the new data phase.
  task automatic bus(input logic [1:0] trans, input logic wr, input logic [2:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd);
    int          stalls;
    logic [31:0] exp;
    logic [7:0]  idx;
    logic [3:0]  be;
    logic        err;
    hsel0  = ~use2;
    hsel2  = use2;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = addr;
    HWDATA = dp_wdata;
    stalls = 0;
    @(negedge HCLK);
    while (!rdy && stalls < 16) begin
      stalls++;
      if (dp_act) chk("resp_stall", 32'(resp), 32'(dp_err));
      @(negedge HCLK);
    end
    if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
    if (dp_act) begin
      chk("wait_cycles", 32'(stalls), 32'(dp_ws));
      chk("hresp", 32'(resp), 32'(dp_err));
      if (dp_rd) begin
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          exp = sb_q.pop_front();
          chk("hrdata", rdata, exp);
        end
      end
    end
    @(posedge HCLK);
    #1;
    err      = trans[1] & tb_err(sz, addr);
    dp_act   = 1'b1;
    dp_rd    = trans[1] & ~wr;
    dp_err   = err;
    dp_wdata = wd;
    dp_ws    = err ? 1 : ((trans[1] && !wr && use2) ? 2 : 0);
    idx      = addr[9:2];
    be       = tb_be(sz, addr[1:0]);
    if (trans[1] && !wr) begin
      if (err)       sb_q.push_back(32'h0);
      else if (use2) sb_q.push_back(mem2[idx]);
      else           sb_q.push_back(mem0[idx]);
    end else if (trans[1] && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (use2) mem2[idx][8*i +: 8] = wd[8*i +: 8];
          else      mem0[idx][8*i +: 8] = wd[8*i +: 8];
        end
      end
    end
  endtask

  task automatic idle();
    bus(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    HRESETn = 1'b0; use2 = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0;
    HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HBURST = 3'b000;
    HPROT = 4'b0011; HTRANS = HTRANS_IDLE; HMASTLOCK = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_ready0", 32'(hreadyout0), 32'd1);
    chk("rst_resp0",  32'(hresp0),     32'd0);
    chk("rst_rdata0", hrdata0,         32'h0);
    chk("rst_ready2", 32'(hreadyout2), 32'd1);
    chk("rst_resp2",  32'(hresp2),     32'd0);
    chk("rst_rdata2", hrdata2,         32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // write then immediate read of the same word
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0, 32'hDEADBEEF);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    idle();

    // sub-word writes merged into a pending word, read with no stall
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD,  32'h4, 32'h11223344);
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE,  32'h5, 32'h0000AA00);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h4, 32'h0);
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_HWORD, 32'h6, 32'hBEEF0000);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h4, 32'h0);
    idle();
    idle();
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  32'h4, 32'h0);
    idle();

    // two-wait-state instance
    use2 = 1'b1;
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8, 32'h0BADF00D);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8, 32'h0);
    idle();
    idle();
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8, 32'h0);
    idle();
    use2 = 1'b0;

    // address beyond the memory: error response, or wrap to word 0
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h400, 32'h0);
    idle();

    // SEQ burst with BUSY and IDLE cycles interleaved
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'hA0A00001);
    bus(HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h24, 32'h0);
    bus(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h24, 32'hA0A00002);
    idle();
    bus(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h28, 32'hA0A00003);
    bus(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h2C, 32'hA0A00004);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    bus(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h24, 32'h0);
    bus(HTRANS_BUSY,   1'b0, HSIZE_WORD, 32'h28, 32'h0);
    bus(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h28, 32'h0);
    idle();
    bus(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h2C, 32'h0);
    idle();

    // reset pulse during a write data phase discards the write
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h55667788);
    idle();
    idle();
    saved = mem0[4];
    bus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hCAFEF00D);
    mem0[4] = saved;
    HWDATA  = 32'hCAFEF00D;
    HTRANS  = HTRANS_IDLE;
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_ready", 32'(hreadyout0), 32'd1);
    chk("midrst_resp",  32'(hresp0),     32'd0);
    chk("midrst_rdata", hrdata0,         32'h0);
    @(negedge HCLK);
    chk("midrst_ready_hold", 32'(hreadyout0), 32'd1);
    chk("midrst_rdata_hold", hrdata0,         32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    dp_act = 1'b0;
    dp_rd  = 1'b0;
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    bus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0,  32'h0);
    idle();
    idle();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_spram_ahb3_fwd.md
PERIPHERAL_SPRAM_AHB3_FWD -- requirements
Module: peripheral_spram_ahb3_fwd

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: memory depth in XLEN-bit words, power of 2.
REQ-002 SHALL have parameter PLEN, default 32: HADDR width.
REQ-003 SHALL have parameter XLEN, default 32: data width, power of 2 in 8..1024.
REQ-004 SHALL have parameter WAIT_STATES, default 0: extra read wait states, 0..3.
REQ-005 SHALL have parameter TECHNOLOGY, default "GENERIC": passed to the memory wrapper.
REQ-006 SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port HCLK, input, 1 bit: clock.
REQ-008 SHALL have AHB-Lite slave inputs HSEL 1, HADDR PLEN, HWDATA XLEN, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HTRANS 2, HMASTLOCK 1, HREADY 1.
REQ-009 SHALL have outputs HRDATA XLEN, HREADYOUT 1 and HRESP 1.

Function
REQ-010 SHALL accept a transfer only when HSEL & HREADY and HTRANS is NONSEQ or SEQ.
REQ-011 SHALL answer IDLE and BUSY with zero-wait OKAY and make no memory access.
REQ-012 SHALL capture write address and byte enables in the address phase, latch HWDATA in the data phase, and commit it to memory on the following edge (posted write).
REQ-013 SHALL derive byte enables from HSIZE and HADDR[log2(XLEN/8)-1:0]; lanes outside XLEN SHALL be dropped.
REQ-014 SHALL complete writes with zero wait states in all cases.
REQ-015 SHALL return read data in the cycle after the address phase when WAIT_STATES=0; otherwise SHALL hold HREADYOUT low for exactly WAIT_STATES data-phase cycles.
REQ-016 SHALL NOT stall a read that hits the word of a pending or committing posted write; it SHALL forward the pending bytes per byte enable, merged with memory data.
REQ-017 SHALL on back-to-back writes to the same word hold the later write's bytes and commit the earlier write first.
REQ-018 SHALL implement the FSM states IDLE, RD_WAIT, ERR1 and ERR2.
REQ-019 FSM: IDLE->RD_WAIT on an accepted read with WAIT_STATES>0; RD_WAIT->IDLE after the counter expires; IDLE->ERR1 on an error transfer (REQ-027); ERR1->ERR2->IDLE unconditionally.
REQ-020 SHALL keep a 2-bit wait counter that loads WAIT_STATES on entry to RD_WAIT and decrements to 0.
REQ-021 SHALL index words with HADDR[log2(XLEN/8) +: log2(MEM_DEPTH)], wrapping modulo MEM_DEPTH when REQ-027 is disabled.
REQ-022 SHALL ignore HBURST, HPROT and HMASTLOCK; SEQ accesses SHALL be handled identically to NONSEQ.

Reset
REQ-023 SHALL while reset is asserted drive HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE and wait counter=0.
REQ-024 SHALL on reset asserted mid-transfer discard any uncommitted posted write; memory contents SHALL NOT be reset.
REQ-025 SHALL register all control state on the asynchronous reset; the data path SHALL have no reset.

Configuration
REQ-026 SHALL define macro PERIPHERAL_SPRAM_AHB3_ERROR_EN; without it, HRESP SHALL be tied OKAY and ERR1/ERR2 SHALL be unreachable.
REQ-027 SHALL with the macro treat as errors: word index >= MEM_DEPTH when PLEN address space exceeds the memory; HSIZE wider than XLEN; and an address misaligned to HSIZE.
REQ-028 SHALL respond to an error transfer with ERR1 (HRESP=ERROR, HREADYOUT=0) then ERR2 (HRESP=ERROR, HREADYOUT=1); no memory write, and HRDATA=0.

Structure
REQ-029 SHALL place HTRANS/HSIZE/HRESP encodings and the FSM state enum in shared package peripheral_ahb3_pkg.
REQ-030 SHALL instantiate one memory sub-module, peripheral_spram_1r1w (ABITS=log2(MEM_DEPTH), DBITS=XLEN, byte enables); forwarding, FSM and byte-enable logic SHALL live in this module.

Verification
REQ-031 Bench SHALL check: write word 0x0 = 0xDEADBEEF, then immediate read 0x0 -> HRDATA 0xDEADBEEF next cycle, HREADYOUT never low (WAIT_STATES=0).
REQ-032 Bench SHALL check: byte write 0xAA to 0x5, then read 0x4 -> 0x????AA?? merged with the prior word contents, no stall.
REQ-033 Bench SHALL check: WAIT_STATES=2, read 0x8 -> HREADYOUT low 2 cycles, then data valid.
REQ-034 Bench SHALL check, with ERROR_EN and MEM_DEPTH=256/XLEN=32: read 0x400 -> two-cycle ERROR, HREADYOUT 0 then 1.
REQ-035 Bench SHALL check: HRESETn pulsed during a write data phase -> outputs at reset values and the target word unchanged.
REQ-036 Bench SHALL check: IDLE/BUSY interleaved in a SEQ burst of 4 words -> all OKAY with zero wait, data correct.
